// File: rtl/elevator_pkg.sv
// Shared encodings and helpers for the 4-floor elevator controller and its segment display.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned FLOOR_W    = 2;

  localparam logic DIR_UP        = 1'b1;
  localparam logic DIR_DOWN      = 1'b0;
  localparam logic DOOR_OPEN_V   = 1'b1;
  localparam logic DOOR_CLOSED_V = 1'b0;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE_UP   = 2'd1;
  localparam logic [1:0] MOVE_DOWN = 2'd2;
  localparam logic [1:0] DOOR_OPEN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = IDLE,
    ST_MOVE_UP   = MOVE_UP,
    ST_MOVE_DOWN = MOVE_DOWN,
    ST_DOOR_OPEN = DOOR_OPEN
  } state_e;

  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

  // Floors strictly above / below f.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (i > 32'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (i < 32'(f));
    return m;
  endfunction

endpackage

// File: rtl/elevator_controller_timer.sv
// Shared travel/door timer: clear, count-enable, saturating, terminal-count flag against limit.
module elevator_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign done_c = (count == limit);

endmodule

// File: rtl/elevator_controller.sv
// Car-motion and door FSM for the 4-floor elevator; drives segment_controller directly.
// Optional DOOR_REOPEN_EN adds a door_btn input that holds or reopens the door.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int unsigned FLOOR_TICKS = 50_000_000,
  parameter int unsigned DOOR_TICKS  = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DOOR_REOPEN_EN
  input  logic                  door_btn,
`endif
  input  logic [NUM_FLOORS-1:0] call_btn,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  ud_state,
  output logic                  oc_state,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int unsigned TIMER_W   = $clog2(MAX_TICKS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  state_e                  state;
  state_e                  nxt_state;
  logic [FLOOR_W-1:0]      nxt_floor;
  logic                    nxt_ud;
  logic [NUM_FLOORS-1:0]   clr;
  logic [NUM_FLOORS-1:0]   req;
  logic [NUM_FLOORS-1:0]   above_p;
  logic [NUM_FLOORS-1:0]   below_p;
  logic [FLOOR_W-1:0]      floor_up;
  logic [FLOOR_W-1:0]      floor_dn;
  logic                    timer_restart;
  logic                    timer_clr;
  logic                    timer_en;
  logic                    timer_done_c;
  logic [TIMER_W-1:0]      timer_limit;
  logic                    door_hold;
  logic                    idle_door_req;

  assign req      = pending | call_btn;
  assign above_p  = pending & above_mask(current_floor);
  assign below_p  = pending & below_mask(current_floor);
  assign floor_up = current_floor + FLOOR_W'(1);
  assign floor_dn = current_floor - FLOOR_W'(1);

`ifdef DOOR_REOPEN_EN
  assign door_hold     = call_btn[current_floor] | door_btn;
  assign idle_door_req = door_btn;
`else
  assign door_hold     = call_btn[current_floor];
  assign idle_door_req = 1'b0;
`endif

  // Next-state, floor, direction and served-request decision.
  always_comb begin
    nxt_state     = state;
    nxt_floor     = current_floor;
    nxt_ud        = ud_state;
    clr           = '0;
    timer_restart = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending[current_floor]) begin
          nxt_state = ST_DOOR_OPEN;
          clr       = floor_bit(current_floor);
        end else if ((ud_state == DIR_UP) && (|above_p)) begin
          nxt_state = ST_MOVE_UP;
        end else if ((ud_state == DIR_DOWN) && (|below_p)) begin
          nxt_state = ST_MOVE_DOWN;
        end else if (|above_p) begin
          nxt_ud    = DIR_UP;
          nxt_state = ST_MOVE_UP;
        end else if (|below_p) begin
          nxt_ud    = DIR_DOWN;
          nxt_state = ST_MOVE_DOWN;
        end else if (idle_door_req) begin
          nxt_state = ST_DOOR_OPEN;
        end
      end
      ST_MOVE_UP: begin
        if (current_floor == TOP_FLOOR) begin
          nxt_state = ST_IDLE;
        end else if (timer_done_c) begin
          nxt_floor = floor_up;
          if (req[floor_up]) begin
            nxt_state = ST_DOOR_OPEN;
            clr       = floor_bit(floor_up);
          end else if (|(req & above_mask(floor_up))) begin
            timer_restart = 1'b1;
          end else begin
            nxt_state = ST_IDLE;
          end
        end
      end
      ST_MOVE_DOWN: begin
        if (current_floor == '0) begin
          nxt_state = ST_IDLE;
        end else if (timer_done_c) begin
          nxt_floor = floor_dn;
          if (req[floor_dn]) begin
            nxt_state = ST_DOOR_OPEN;
            clr       = floor_bit(floor_dn);
          end else if (|(req & below_mask(floor_dn))) begin
            timer_restart = 1'b1;
          end else begin
            nxt_state = ST_IDLE;
          end
        end
      end
      ST_DOOR_OPEN: begin
        // Calls for the open floor are absorbed and only extend the door time.
        clr = floor_bit(current_floor);
        if (door_hold) begin
          timer_restart = 1'b1;
        end else if (timer_done_c) begin
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  assign timer_clr   = timer_restart | (nxt_state != state);
  assign timer_en    = (state != ST_IDLE);
  assign timer_limit = (state == ST_DOOR_OPEN) ? TIMER_W'(DOOR_TICKS - 1)
                                               : TIMER_W'(FLOOR_TICKS - 1);

  elevator_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .limit  (timer_limit),
    .done_c (timer_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      current_floor <= '0;
      ud_state      <= DIR_UP;
      oc_state      <= DOOR_CLOSED_V;
      pending       <= '0;
    end else begin
      state         <= nxt_state;
      current_floor <= nxt_floor;
      ud_state      <= nxt_ud;
      oc_state      <= (nxt_state == ST_DOOR_OPEN) ? DOOR_OPEN_V : DOOR_CLOSED_V;
      pending       <= req & ~clr;
    end
  end

endmodule
